spawn_scheduler: RTL and testbench
==================================

# spawn_scheduler

Frame-based scheduler that decides when and in which lane the next obstacle is spawned, and how fast obstacles scroll. It sits between the game timer and random source on one side and the obstacle slot table on the other. It owns the difficulty ramp, the randomized spawn delay and per-lane spacing, and it issues one spawn request at a time over a valid/ready handshake.

## Interface
- LANE_GAP, 8: frames a lane stays blocked after a spawn into it (1..15).
- MAX_OBSTACLES, 10: slot table capacity; target_active never exceeds it.
- WAIT_SHIFT, 2: spawn delay in frames = random_num << WAIT_SHIFT.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- game_reset  in  1  synchronous restart; identical effect to rst_in
- frame_trigger  in  1  one-cycle pulse per video frame
- time_alive  in  12  seconds survived in the current game
- curr_active  in  4  number of active obstacles in the slot table
- random_num  in  4  random value, sampled when a delay is loaded
- random_lane  in  2  random lane; sampled on delay expiry
- spawn_valid  out  1  spawn request pending
- spawn_lane  out  2  lane of the pending request (0..2)
- spawn_ready  in  1  slot table accepts the request this cycle
- speed  out  3  scroll speed in pixels per frame
- target_active  out  4  desired obstacle count for the current difficulty

## Operation
- Difficulty is recomputed from time_alive on the thresholds 0/30/60/120/150/180/210/240/270/300/330 s.
  - Target by threshold: 0/1/2/3/4/5/6/7/8/9/10. Speed by threshold: 1/2/3/4/5/5/6/6/7/7/7.
  - The result registers only on frame_trigger. It is monotonic: a smaller value is never loaded.
  - target_active is clamped to MAX_OBSTACLES.
- FSM states: IDLE, WAIT, REQUEST.
  - IDLE: if curr_active < target_active, load delay = random_num << WAIT_SHIFT (6-bit, 0..60) and go to WAIT.
  - WAIT: the delay decrements on each frame_trigger. At delay 0, pick a lane and go to REQUEST.
    - If no lane is free, stay in WAIT with delay 0 and re-evaluate every cycle.
  - REQUEST: spawn_valid=1 and spawn_lane is held stable until spawn_ready.
    - On valid&&ready: load that lane's cooldown with LANE_GAP and go to IDLE.
- Lane pick:
  - Candidate c = random_lane, with 3 mapped to 0.
  - Choose the first lane of c, (c+1)%3, (c+2)%3 whose cooldown is 0.
- Cooldowns: three 4-bit counters.
  - Each decrements on frame_trigger and saturates at 0.
  - A load on the same cycle as frame_trigger wins.
- The block does not re-check curr_active in REQUEST. The slot table deasserts spawn_ready when it is full, and the request waits indefinitely.

## Timing
- Reset or game_reset values: state IDLE, spawn_valid 0, spawn_lane 0, speed 1, target_active 0, delay 0, all cooldowns 0. Asserting either mid-REQUEST drops spawn_valid on the next edge and the request is never accepted.
- IDLE→WAIT takes 1 cycle. With delay 0, WAIT→REQUEST takes 1 more cycle, so spawn_valid first asserts 2 cycles after the IDLE condition is met.
- The handshake completes on the edge where spawn_valid&&spawn_ready. spawn_valid is 0 the following cycle, and IDLE may re-request one cycle after that.
- curr_active is assumed to reflect an accepted spawn no later than 1 cycle after acceptance. IDLE samples it the cycle after returning.
- speed and target_active change only on the cycle after a frame_trigger.

## Configuration
- SPAWN_LANE_GAP_EN defined: per-lane cooldowns and lane rotation as above.
- SPAWN_LANE_GAP_EN undefined:
  - No cooldown counters and no rotation.
  - Lane = random_lane with 3 mapped to 0.
  - WAIT→REQUEST happens directly at delay 0.
  - LANE_GAP is ignored.

## Test plan
- Ramp: time_alive=0 → speed 1, target 0, no spawns. Step time_alive to 65, pulse frame_trigger → next cycle speed 3, target 2. Step time_alive back to 40 → values unchanged.
- Delay: target 1, curr_active 0, random_num 5 → spawn_valid rises after exactly 20 frame_triggers (+1 cycle). With random_num 0 → rises 2 cycles after entry.
- Backpressure: hold spawn_ready 0 for 50 cycles → spawn_valid stays 1 and spawn_lane is stable. Ready for 1 cycle → spawn_valid 0 the next cycle.
- Lane gap (macro on, LANE_GAP 8): spawn in lane 1, then random_lane=1 within 8 frames → lane 2 issued. With all lanes cooling → no request until a cooldown reaches 0. random_lane=3 → lane 0.
- Macro off: random_lane=1 twice in a row → both requests go to lane 1.
- game_reset asserted in REQUEST → spawn_valid 0, speed 1, target 0 next cycle, and no handshake occurs.

Source files
------------

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: difficulty ramp, random spawn delay and lane pick with valid/ready request; SPAWN_LANE_GAP_EN enables per-lane cooldowns
module spawn_scheduler #(
  parameter int LANE_GAP      = 8,
  parameter int MAX_OBSTACLES = 10,
  parameter int WAIT_SHIFT    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        game_reset,
  input  logic        frame_trigger,
  input  logic [11:0] time_alive,
  input  logic [3:0]  curr_active,
  input  logic [3:0]  random_num,
  input  logic [1:0]  random_lane,
  output logic        spawn_valid,
  output logic [1:0]  spawn_lane,
  input  logic        spawn_ready,
  output logic [2:0]  speed,
  output logic [3:0]  target_active
);
  typedef enum logic [1:0] {IDLE, WAIT, REQUEST} state_t;
  state_t state, state_nxt;
  logic       rst;
  logic [5:0] delay;
  logic [3:0] lvl, tgt_new;
  logic [2:0] spd_new;
  logic [1:0] c, pick;
  logic       free;
  assign rst = rst_in | game_reset;
  assign lvl = time_alive >= 12'd330 ? 4'd10 :
               time_alive >= 12'd300 ? 4'd9  :
               time_alive >= 12'd270 ? 4'd8  :
               time_alive >= 12'd240 ? 4'd7  :
               time_alive >= 12'd210 ? 4'd6  :
               time_alive >= 12'd180 ? 4'd5  :
               time_alive >= 12'd150 ? 4'd4  :
               time_alive >= 12'd120 ? 4'd3  :
               time_alive >= 12'd60  ? 4'd2  :
               time_alive >= 12'd30  ? 4'd1  : 4'd0;
  assign spd_new = lvl >= 4'd8 ? 3'd7 : lvl >= 4'd6 ? 3'd6 : lvl >= 4'd4 ? 3'd5 : 3'(lvl + 4'd1);
  assign tgt_new = lvl > 4'(MAX_OBSTACLES) ? 4'(MAX_OBSTACLES) : lvl;
  assign c = random_lane == 2'd3 ? 2'd0 : random_lane;
`ifdef SPAWN_LANE_GAP_EN
  logic [2:0][3:0] cool;
  logic [1:0]      c1, c2;
  assign c1   = c == 2'd2 ? 2'd0 : c + 2'd1;
  assign c2   = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  assign pick = cool[c] == 4'd0 ? c : cool[c1] == 4'd0 ? c1 : c2;
  assign free = cool[c] == 4'd0 || cool[c1] == 4'd0 || cool[c2] == 4'd0;
  // a load on acceptance overrides the frame decrement
  always_ff @(posedge clk_in)
    for (int i = 0; i < 3; i++)
      cool[i] <= rst ? 4'd0 :
                 (spawn_valid && spawn_ready && spawn_lane == 2'(i)) ? 4'(LANE_GAP) :
                 (frame_trigger && cool[i] != 4'd0) ? cool[i] - 4'd1 : cool[i];
`else
  logic unused_gap;
  assign unused_gap = LANE_GAP != 0;
  assign pick = c;
  assign free = 1'b1;
`endif
  always_ff @(posedge clk_in) state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = (state == IDLE && curr_active < target_active) ? WAIT :
                (state == WAIT && delay == 6'd0 && free) ? REQUEST :
                (state == REQUEST && spawn_ready) ? IDLE : state;
  always_comb spawn_valid = state == REQUEST;
  always_ff @(posedge clk_in) begin
    if (rst) begin
      delay         <= 6'd0;
      spawn_lane    <= 2'd0;
      speed         <= 3'd1;
      target_active <= 4'd0;
    end else begin
      if (frame_trigger) begin
        speed         <= spd_new > speed ? spd_new : speed;
        target_active <= tgt_new > target_active ? tgt_new : target_active;
      end
      if (state == IDLE && state_nxt == WAIT)
        delay <= {2'b00, random_num} << WAIT_SHIFT;
      else if (state == WAIT && frame_trigger && delay != 6'd0)
        delay <= delay - 6'd1;
      if (state == WAIT && state_nxt == REQUEST)
        spawn_lane <= pick;
    end
  end
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: randomized and directed checks of spawn_scheduler against a behavioural model
module tb_spawn_scheduler;
  logic clk_in = 0, rst_in = 1, game_reset = 0, frame_trigger = 0, spawn_ready = 0;
  logic [11:0] time_alive = 0;
  logic [3:0] curr_active = 0, random_num = 0;
  logic [1:0] random_lane = 0;
  logic spawn_valid;
  logic [1:0] spawn_lane;
  logic [2:0] speed;
  logic [3:0] target_active;
  int n_cmp = 0, n_fail = 0;
  int thr[10] = '{30, 60, 120, 150, 180, 210, 240, 270, 300, 330};
  int spd_tab[11] = '{1, 2, 3, 4, 5, 5, 6, 6, 7, 7, 7};
  int m_cool[3];

  spawn_scheduler #(.LANE_GAP(8), .MAX_OBSTACLES(10), .WAIT_SHIFT(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .game_reset(game_reset), .frame_trigger(frame_trigger),
    .time_alive(time_alive), .curr_active(curr_active), .random_num(random_num),
    .random_lane(random_lane), .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
    .spawn_ready(spawn_ready), .speed(speed), .target_active(target_active));

  always #5 clk_in = ~clk_in;

  task automatic tick; @(posedge clk_in); #1; endtask
  task automatic frame; frame_trigger = 1; tick(); frame_trigger = 0; endtask
  task automatic model_frame; foreach (m_cool[i]) if (m_cool[i] > 0) m_cool[i]--; endtask
  task automatic do_reset; rst_in = 1; tick(); rst_in = 0; foreach (m_cool[i]) m_cool[i] = 0; endtask
  task automatic set_level(input int t); time_alive = 12'(t); frame(); endtask

  function automatic int level(int t);
    int l = 0;
    foreach (thr[i]) if (t >= thr[i]) l++;
    return l;
  endfunction

  function automatic int model_pick(int rl);
    int cc = (rl == 3) ? 0 : rl;
`ifdef SPAWN_LANE_GAP_EN
    for (int k = 0; k < 3; k++) if (m_cool[(cc + k) % 3] == 0) return (cc + k) % 3;
    return -1;
`else
    return cc;
`endif
  endfunction

  task automatic test_reset;
    rst_in = 1; curr_active = 4'd3; time_alive = 12'd500; frame_trigger = 1;
    tick();
    frame_trigger = 0; rst_in = 0; curr_active = 0; time_alive = 0;
    n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", spawn_valid); end
    n_cmp++; if (spawn_lane !== 2'd0) begin n_fail++; $display("FAIL reset_lane: got %0d want 0", spawn_lane); end
    n_cmp++; if (speed !== 3'd1) begin n_fail++; $display("FAIL reset_speed: got %0d want 1", speed); end
    n_cmp++; if (target_active !== 4'd0) begin n_fail++; $display("FAIL reset_target: got %0d want 0", target_active); end
  endtask

  task automatic test_ramp;
    do_reset(); curr_active = 0;
    set_level(0);
    n_cmp++; if (speed !== 3'd1 || target_active !== 4'd0) begin n_fail++; $display("FAIL ramp_zero: got speed %0d target %0d want 1/0", speed, target_active); end
    repeat (4) tick();
    n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_nospawn: got valid %0b want 0", spawn_valid); end
    curr_active = 15; time_alive = 12'd65; tick();
    n_cmp++; if (speed !== 3'd1 || target_active !== 4'd0) begin n_fail++; $display("FAIL ramp_noframe: got %0d/%0d want 1/0", speed, target_active); end
    frame();
    n_cmp++; if (speed !== 3'd3 || target_active !== 4'd2) begin n_fail++; $display("FAIL ramp_65: got %0d/%0d want 3/2", speed, target_active); end
    set_level(40);
    n_cmp++; if (speed !== 3'd3 || target_active !== 4'd2) begin n_fail++; $display("FAIL ramp_mono: got %0d/%0d want 3/2", speed, target_active); end
  endtask

  task automatic test_random_ramp;
    int base = 0, t, m_spd = 1, m_tgt = 0, l;
    do_reset(); curr_active = 15;
    for (int i = 0; i < 400; i++) begin
      base += int'($urandom_range(0, 3));
      t = base + int'($urandom_range(0, 40)) - 20;
      if (t < 0) t = 0;
      time_alive = 12'(t);
      frame_trigger = ($urandom_range(0, 2) == 0);
      if (frame_trigger) begin
        l = level(t);
        if (spd_tab[l] > m_spd) m_spd = spd_tab[l];
        if ((l > 10 ? 10 : l) > m_tgt) m_tgt = (l > 10 ? 10 : l);
      end
      tick();
      frame_trigger = 0;
      n_cmp++; if (speed !== 3'(m_spd)) begin n_fail++; $display("FAIL rramp_speed t=%0d: got %0d want %0d", t, speed, m_spd); end
      n_cmp++; if (target_active !== 4'(m_tgt)) begin n_fail++; $display("FAIL rramp_target t=%0d: got %0d want %0d", t, target_active, m_tgt); end
    end
  endtask

  task automatic test_delay;
    do_reset(); curr_active = 0; random_num = 4'd5; random_lane = 2'd2;
    set_level(30);
    n_cmp++; if (target_active !== 4'd1 || spawn_valid !== 1'b0) begin n_fail++; $display("FAIL delay_setup: got target %0d valid %0b want 1/0", target_active, spawn_valid); end
    tick();
    random_num = 4'($urandom);
    for (int i = 0; i < 20; i++) begin
      frame();
      n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL delay_early frame %0d: got valid %0b want 0", i, spawn_valid); end
      if (i < 19) begin
        tick();
        n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL delay_gap frame %0d: got valid %0b want 0", i, spawn_valid); end
      end
    end
    tick();
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2) begin n_fail++; $display("FAIL delay_rise: got valid %0b lane %0d want 1/2", spawn_valid, spawn_lane); end
    spawn_ready = 1; curr_active = 1; tick(); spawn_ready = 0;
    n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL delay_accept: got valid %0b want 0", spawn_valid); end
    do_reset(); curr_active = 0; random_num = 0; random_lane = 2'd1;
    set_level(30);
    n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL zero_c0: got %0b want 0", spawn_valid); end
    tick();
    n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL zero_c1: got %0b want 0", spawn_valid); end
    tick();
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd1) begin n_fail++; $display("FAIL zero_c2: got valid %0b lane %0d want 1/1", spawn_valid, spawn_lane); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 50; i++) begin
      random_lane = 2'($urandom); random_num = 4'($urandom); frame_trigger = 1'($urandom);
      tick();
      n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd1) begin n_fail++; $display("FAIL bp_hold %0d: got valid %0b lane %0d want 1/1", i, spawn_valid, spawn_lane); end
    end
    frame_trigger = 0; random_lane = 0; random_num = 0;
    spawn_ready = 1; tick(); spawn_ready = 0;
    n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: got %0b want 0", spawn_valid); end
    tick();
    n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %0b want 0", spawn_valid); end
    tick();
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd0) begin n_fail++; $display("FAIL bp_rereq: got valid %0b lane %0d want 1/0", spawn_valid, spawn_lane); end
    spawn_ready = 1; curr_active = 15; tick(); spawn_ready = 0;
  endtask

  task automatic test_lane_gap;
    do_reset(); curr_active = 0; random_num = 0; random_lane = 2'd1;
    set_level(120); tick(); tick();
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd1) begin n_fail++; $display("FAIL gap_first: got valid %0b lane %0d want 1/1", spawn_valid, spawn_lane); end
    spawn_ready = 1; tick(); spawn_ready = 0; tick(); tick();
`ifdef SPAWN_LANE_GAP_EN
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2) begin n_fail++; $display("FAIL gap_rotate: got valid %0b lane %0d want 1/2", spawn_valid, spawn_lane); end
    spawn_ready = 1; tick(); spawn_ready = 0;
    random_lane = 2'd3; tick(); tick();
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd0) begin n_fail++; $display("FAIL gap_lane3: got valid %0b lane %0d want 1/0", spawn_valid, spawn_lane); end
    spawn_ready = 1; tick(); spawn_ready = 0;
    random_lane = 2'd2;
    repeat (4) begin
      tick();
      n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL gap_blocked: got valid %0b want 0", spawn_valid); end
    end
    for (int i = 0; i < 8; i++) begin
      frame();
      n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL gap_cooling %0d: got valid %0b want 0", i, spawn_valid); end
    end
    tick();
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2) begin n_fail++; $display("FAIL gap_release: got valid %0b lane %0d want 1/2", spawn_valid, spawn_lane); end
`else
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd1) begin n_fail++; $display("FAIL nogap_repeat: got valid %0b lane %0d want 1/1", spawn_valid, spawn_lane); end
`endif
    spawn_ready = 1; curr_active = 15; tick(); spawn_ready = 0;
  endtask

  task automatic test_random_lanes;
    int k, exp, n;
    do_reset(); curr_active = 15; random_num = 0;
    set_level(120);
    for (int it = 0; it < 30; it++) begin
      k = int'($urandom_range(0, 5));
      repeat (k) begin frame(); model_frame(); end
      random_lane = 2'($urandom);
      exp = model_pick(int'(random_lane));
      curr_active = 0; tick(); tick();
      if (exp < 0) begin
        n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL rlane_blocked %0d: got valid %0b want 0", it, spawn_valid); end
        n = 0;
        while (exp < 0 && n < 16) begin frame(); model_frame(); exp = model_pick(int'(random_lane)); n++; end
        tick();
      end
      n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'(exp)) begin n_fail++; $display("FAIL rlane_pick %0d: got valid %0b lane %0d want 1/%0d", it, spawn_valid, spawn_lane, exp); end
      spawn_ready = 1; curr_active = 15; tick(); spawn_ready = 0;
      if (exp >= 0) m_cool[exp] = 8;
      n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL rlane_accept %0d: got valid %0b want 0", it, spawn_valid); end
    end
  endtask

  task automatic test_game_reset;
    do_reset(); curr_active = 0; random_num = 0; random_lane = 2'd2;
    set_level(65); tick(); tick();
    n_cmp++; if (spawn_valid !== 1'b1 || speed !== 3'd3) begin n_fail++; $display("FAIL greset_pre: got valid %0b speed %0d want 1/3", spawn_valid, speed); end
    game_reset = 1; spawn_ready = 1; tick(); game_reset = 0; spawn_ready = 0;
    n_cmp++; if (spawn_valid !== 1'b0 || speed !== 3'd1 || target_active !== 4'd0) begin n_fail++; $display("FAIL greset_post: got valid %0b speed %0d target %0d want 0/1/0", spawn_valid, speed, target_active); end
    repeat (3) tick();
    n_cmp++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL greset_idle: got %0b want 0", spawn_valid); end
    set_level(65); tick(); tick();
    n_cmp++; if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2) begin n_fail++; $display("FAIL greset_nohs: got valid %0b lane %0d want 1/2", spawn_valid, spawn_lane); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_random_ramp();
    test_delay();
    test_backpressure();
    test_lane_gap();
    test_random_lanes();
    test_game_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
